serial_tone_synth: RTL and testbench

- Inverse-direction companion to the serial single-bin DFT correlator.
- Accepts one complex coefficient (re, im) per channel. Serially synthesises FRAME_LENGTH time samples per channel: x[n] = (re*w_re[n] - im*w_im[n]) >>> SHIFT.
- Drives the shared counter-addressed twiddle ROM pair (synchronous read, 1-cycle latency) and streams one sample per channel per cycle to the downstream sample sink.

---
 rtl/serial_tone_synth.sv | 138 +++++++++++++
 tb/tb_serial_tone_synth.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_tone_synth.sv
// Serial tone synthesiser: turns one complex coefficient per channel into
// FRAME_LENGTH time samples using a shared, counter-addressed twiddle ROM pair.
module serial_tone_synth #(
    parameter int W_WIDTH      = 16,
    parameter int X_WIDTH      = 16,
    parameter int S_WIDTH      = 32,
    parameter int FRAME_LENGTH = 10,
    parameter int CHANELS      = 2,
    parameter int SHIFT        = W_WIDTH - 1
) (
    input  logic                                  clk,
    input  logic                                  arst,
    input  logic                                  valid_i,
    input  logic [CHANELS-1:0][S_WIDTH-1:0]       re,
    input  logic [CHANELS-1:0][S_WIDTH-1:0]       im,
    output logic                                  ready_o,
    output logic [$clog2(FRAME_LENGTH)-1:0]       counter,
    input  logic [W_WIDTH-1:0]                    w_re,
    input  logic [W_WIDTH-1:0]                    w_im,
    output logic [CHANELS-1:0][X_WIDTH-1:0]       x,
    output logic                                  valid_o,
    output logic                                  finish
);

    localparam int CW      = $clog2(FRAME_LENGTH);
    localparam int P_WIDTH = S_WIDTH + W_WIDTH + 1;
    localparam logic [CW-1:0] LAST_ADDR = CW'(FRAME_LENGTH - 1);
    localparam logic signed [P_WIDTH-1:0] SAT_MAX =
        {{(P_WIDTH - X_WIDTH + 1){1'b0}}, {(X_WIDTH - 1){1'b1}}};
    localparam logic signed [P_WIDTH-1:0] SAT_MIN =
        {{(P_WIDTH - X_WIDTH + 1){1'b1}}, {(X_WIDTH - 1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, LAST} state_t;

    state_t                          state, state_next;
    logic [CW-1:0]                   counter_next;
    logic                            load, sample_en, last_sample;
    logic [CHANELS-1:0][S_WIDTH-1:0] re_q, im_q;
    logic [CHANELS-1:0][X_WIDTH-1:0] sample_next;

    // Full-width (re*w_re - im*w_im) >>> SHIFT, floored, then clamped to X_WIDTH.
    function automatic logic [X_WIDTH-1:0] synth_sample(
        input logic [S_WIDTH-1:0] c_re,
        input logic [S_WIDTH-1:0] c_im,
        input logic [W_WIDTH-1:0] t_re,
        input logic [W_WIDTH-1:0] t_im
    );
        logic signed [P_WIDTH-1:0] a_re, a_im, b_re, b_im, p, q;
        logic [X_WIDTH-1:0]        result;
        a_re = {{(W_WIDTH + 1){c_re[S_WIDTH-1]}}, c_re};
        a_im = {{(W_WIDTH + 1){c_im[S_WIDTH-1]}}, c_im};
        b_re = {{(S_WIDTH + 1){t_re[W_WIDTH-1]}}, t_re};
        b_im = {{(S_WIDTH + 1){t_im[W_WIDTH-1]}}, t_im};
        p    = a_re * b_re - a_im * b_im;
        q    = p >>> SHIFT;
        if (q > SAT_MAX)      result = SAT_MAX[X_WIDTH-1:0];
        else if (q < SAT_MIN) result = SAT_MIN[X_WIDTH-1:0];
        else                  result = q[X_WIDTH-1:0];
        return result;
    endfunction

    assign ready_o = (state == IDLE);

    // NOTE: every signal in this block gets a default first, so no latch is inferred.
    always_comb begin
        state_next   = state;
        counter_next = counter;
        load         = 1'b0;
        sample_en    = 1'b0;
        last_sample  = 1'b0;
        case (state)
            IDLE: begin
                counter_next = '0;
                if (valid_i) begin
                    load         = 1'b1;
                    counter_next = CW'(1);
                    state_next   = RUN;
                end
            end
            RUN: begin
                sample_en = 1'b1;
                if (counter == LAST_ADDR) begin
                    counter_next = '0;
                    state_next   = LAST;
                end else begin
                    counter_next = counter + CW'(1);
                end
            end
            LAST: begin
                sample_en    = 1'b1;
                last_sample  = 1'b1;
                counter_next = '0;
                state_next   = IDLE;
            end
            default: begin
                counter_next = '0;
                state_next   = IDLE;
            end
        endcase
    end

    always_comb begin
        sample_next = '0;
        for (int c = 0; c < CHANELS; c++)
            sample_next[c] = synth_sample(re_q[c], im_q[c], w_re, w_im);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state   <= IDLE;
            counter <= '0;
        end else begin
            state   <= state_next;
            counter <= counter_next;
        end
    end

    // x is only loaded while a frame streams, so it holds between frames.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            re_q    <= '0;
            im_q    <= '0;
            x       <= '0;
            valid_o <= 1'b0;
            finish  <= 1'b0;
        end else begin
            if (load) begin
                re_q <= re;
                im_q <= im;
            end
            if (sample_en) x <= sample_next;
            valid_o <= sample_en;
            finish  <= last_sample;
        end
    end

endmodule

// File: tb/tb_serial_tone_synth.sv
// Bench for serial_tone_synth: directed steps plus random coefficients, all
// checked against a frame-level reference model with a 1-cycle-latency ROM.
module tb_serial_tone_synth;

    localparam int W  = 16;
    localparam int X  = 16;
    localparam int S  = 32;
    localparam int FL = 4;
    localparam int CH = 2;
    localparam int SH = W - 1;
    localparam int CW = $clog2(FL);

    logic                  clk = 1'b0;
    logic                  arst = 1'b1;
    logic                  valid_i = 1'b0;
    logic [CH-1:0][S-1:0]  re = '0;
    logic [CH-1:0][S-1:0]  im = '0;
    logic                  ready_o;
    logic [CW-1:0]         counter;
    logic [W-1:0]          w_re = 16'sd32767;
    logic [W-1:0]          w_im = 16'sd0;
    logic [CH-1:0][X-1:0]  x;
    logic                  valid_o;
    logic                  finish;

    int rom_re [FL] = '{32767, 0, -32767, 0};
    int rom_im [FL] = '{0, -32767, 0, 32767};

    int tests = 0;
    int fails = 0;

    // Reference model: frame-level view of the synthesiser.
    bit          m_idle;
    int          m_n;
    longint      m_re [CH];
    longint      m_im [CH];
    logic [X-1:0] m_x [CH];
    bit          m_valid;
    bit          m_finish;

    serial_tone_synth #(
        .W_WIDTH(W), .X_WIDTH(X), .S_WIDTH(S),
        .FRAME_LENGTH(FL), .CHANELS(CH), .SHIFT(SH)
    ) dut (
        .clk(clk), .arst(arst), .valid_i(valid_i), .re(re), .im(im),
        .ready_o(ready_o), .counter(counter), .w_re(w_re), .w_im(w_im),
        .x(x), .valid_o(valid_o), .finish(finish)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        w_re <= W'(rom_re[counter]);
        w_im <= W'(rom_im[counter]);
    end

    function automatic logic [X-1:0] expect_sample(longint r, longint i, int n);
        longint p;
        longint hi;
        longint lo;
        hi = (longint'(1) <<< (X - 1)) - 1;
        lo = -(longint'(1) <<< (X - 1));
        p  = r * rom_re[n] - i * rom_im[n];
        p  = p >>> SH;
        if (p > hi) p = hi;
        if (p < lo) p = lo;
        return X'(p);
    endfunction

    task automatic model_reset();
        m_idle   = 1'b1;
        m_n      = 0;
        m_valid  = 1'b0;
        m_finish = 1'b0;
        for (int c = 0; c < CH; c++) begin
            m_re[c] = 0;
            m_im[c] = 0;
            m_x[c]  = '0;
        end
    endtask

    task automatic model_edge();
        if (m_idle) begin
            m_valid  = 1'b0;
            m_finish = 1'b0;
            if (valid_i) begin
                for (int c = 0; c < CH; c++) begin
                    m_re[c] = longint'($signed(re[c]));
                    m_im[c] = longint'($signed(im[c]));
                end
                m_idle = 1'b0;
                m_n    = 0;
            end
        end else begin
            for (int c = 0; c < CH; c++) m_x[c] = expect_sample(m_re[c], m_im[c], m_n);
            m_valid  = 1'b1;
            m_finish = (m_n == FL - 1);
            m_n++;
            if (m_n == FL) m_idle = 1'b1;
        end
    endtask

    task automatic check_all(input string tag);
        logic [CW-1:0] exp_cnt;
        // The ROM address runs one ahead of the sample being produced.
        exp_cnt = m_idle ? CW'(0) : CW'((m_n + 1) % FL);
        tests++;
        assert (ready_o === m_idle) else begin
            fails++;
            $error("FAIL %s ready_o got %0b expected %0b", tag, ready_o, m_idle);
        end
        tests++;
        assert (valid_o === m_valid) else begin
            fails++;
            $error("FAIL %s valid_o got %0b expected %0b", tag, valid_o, m_valid);
        end
        tests++;
        assert (finish === m_finish) else begin
            fails++;
            $error("FAIL %s finish got %0b expected %0b", tag, finish, m_finish);
        end
        tests++;
        assert (counter === exp_cnt) else begin
            fails++;
            $error("FAIL %s counter got %0d expected %0d", tag, counter, exp_cnt);
        end
        for (int c = 0; c < CH; c++) begin
            tests++;
            assert (x[c] === m_x[c]) else begin
                fails++;
                $error("FAIL %s x[%0d] got %0d expected %0d", tag, c,
                       $signed(x[c]), $signed(m_x[c]));
            end
        end
    endtask

    // One clock: drive at the falling edge, model the rising edge, check at the next fall.
    task automatic cycle(input string tag, input bit v, input longint r0, input longint i0,
                         input longint r1, input longint i1);
        valid_i = v;
        re[0] = S'(r0);
        im[0] = S'(i0);
        re[1] = S'(r1);
        im[1] = S'(i1);
        @(posedge clk);
        if (arst) model_reset();
        else      model_edge();
        @(negedge clk);
        check_all(tag);
    endtask

    function automatic longint rand_coef();
        longint v;
        v = longint'($signed($urandom()));
        return v >>> $urandom_range(0, 31);
    endfunction

    initial begin
        model_reset();
        @(negedge clk);

        // Reset held for 3 cycles with valid_i asserted: nothing is accepted.
        for (int k = 0; k < 3; k++) cycle("reset", 1'b1, 77, 88, 99, 11);
        arst = 1'b0;
        cycle("post_reset", 1'b0, 0, 0, 0, 0);

        // Real tone on ch0, quadrature tone on ch1.
        cycle("tone_acc", 1'b1, 1000, 0, 0, 1000);
        for (int k = 0; k < FL + 2; k++) cycle("tone", 1'b0, 0, 0, 0, 0);

        // Saturation on ch0, negative coefficient on ch1.
        cycle("sat_acc", 1'b1, 100000, 0, -1000, 0);
        for (int k = 0; k < FL + 1; k++) cycle("sat", 1'b0, 0, 0, 0, 0);

        // Coefficient offered mid-frame is dropped.
        cycle("busy_acc", 1'b1, 1000, 0, 0, 1000);
        cycle("busy_s0", 1'b0, 0, 0, 0, 0);
        cycle("busy_offer", 1'b1, 5, 5, 5, 5);
        cycle("busy_s2", 1'b0, 0, 0, 0, 0);
        for (int k = 0; k < FL + 2; k++) cycle("busy_tail", 1'b0, 0, 0, 0, 0);

        // Back-to-back: valid_i held high.
        for (int k = 0; k < 3 * (FL + 1); k++)
            cycle("b2b", 1'b1, 1000 + k, -k, 3 * k, 2000);
        cycle("b2b_end", 1'b0, 0, 0, 0, 0);
        for (int k = 0; k < FL + 1; k++) cycle("b2b_drain", 1'b0, 0, 0, 0, 0);

        // Mid-frame reset after the second sample.
        cycle("mrst_acc", 1'b1, 1000, 0, 0, 1000);
        cycle("mrst_s0", 1'b0, 0, 0, 0, 0);
        cycle("mrst_s1", 1'b0, 0, 0, 0, 0);
        arst = 1'b1;
        #1;
        model_reset();
        check_all("mrst_async");
        cycle("mrst_hold", 1'b0, 0, 0, 0, 0);
        arst = 1'b0;
        for (int k = 0; k < 2; k++) cycle("mrst_idle", 1'b0, 0, 0, 0, 0);
        cycle("mrst_acc2", 1'b1, -1000, 0, 100000, 0);
        for (int k = 0; k < FL + 1; k++) cycle("mrst_frame", 1'b0, 0, 0, 0, 0);

        // Random coefficients and random valid_i pattern.
        for (int k = 0; k < 400; k++)
            cycle("random", ($urandom_range(0, 3) == 0),
                  rand_coef(), rand_coef(), rand_coef(), rand_coef());
        for (int k = 0; k < FL + 2; k++) cycle("rand_drain", 1'b0, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
